lsu_stage: RTL and testbench
============================

// Module: lsu_stage
// PURPOSE
// - Load/store unit between the execute stage and the data-memory port; one access in flight.
// - Takes the effective address (ex_data_o) and store data (rdata2_store_o) from the execute stage.
// - Drives a req/gnt/rvalid data-memory bus.
// - Returns load data aligned and sign/zero-extended, or an error for misaligned accesses.
// PARAMETERS
// WORD_WIDTH  32  data/address width; only 32 is supported
// PORTS
// clk               in   1   core clock, rising edge
// rst_n             in   1   asynchronous active-low reset
// lsu_req_i         in   1   execute stage requests an access; fields valid while high
// lsu_we_i          in   1   1=store, 0=load
// lsu_size_i        in   2   00=byte 01=half 10=word; 11 is illegal (treated as misaligned)
// lsu_sign_ext_i    in   1   loads: 1=sign-extend, 0=zero-extend
// lsu_addr_i        in   32  effective address
// lsu_wdata_i       in   32  store data, LSB-justified
// lsu_ready_o       out  1   block is in IDLE and accepts lsu_req_i this cycle
// lsu_valid_o       out  1   one-cycle pulse: access completed
// lsu_rdata_o       out  32  extended load data; valid with lsu_valid_o; 0 for stores
// lsu_err_o         out  1   one-cycle pulse: misaligned/illegal access, no bus traffic
// data_req_o        out  1   bus request
// data_gnt_i        in   1   bus grant
// data_addr_o       out  32  word-aligned bus address ({addr[31:2],2'b00})
// data_we_o         out  1   bus write enable
// data_be_o         out  4   byte enables
// data_wdata_o      out  32  lane-shifted store data
// data_rvalid_i     in   1   response valid (returned for loads and stores)
// data_rdata_i      in   32  bus read data
// BEHAVIOUR
// Reset:
// - All outputs 0, except lsu_ready_o=1; state=IDLE.
// - Registered fields cleared.
// - A reset mid-access drops the access; any later data_rvalid_i seen in IDLE is ignored.
// FSM: IDLE -> REQ -> RESP -> IDLE
// - IDLE
//   - lsu_ready_o=1.
//   - lsu_req_i with a legal alignment: register addr, we, size, sign_ext and lane-shifted wdata/be; go to REQ.
//   - lsu_req_i misaligned/illegal: lsu_err_o=1 next cycle, stay in IDLE, no data_req_o.
// - REQ
//   - data_req_o=1; addr/we/be/wdata held stable from registers until data_gnt_i.
//   - data_gnt_i=1: go to RESP; data_req_o deasserts the next cycle.
// - RESP
//   - Wait for data_rvalid_i. On rvalid, register the result, pulse lsu_valid_o the next cycle, go to IDLE.
//   - rvalid in the same cycle as gnt is not expected: the response is sampled only in RESP.
// Alignment (off = addr[1:0]):
// - Byte: any off.
// - Half: off[0]==0.
// - Word: off==00.
// - size 11 is always an error.
// Byte enables and store data:
// - be = (size==0 ? 4'b0001 : size==1 ? 4'b0011 : 4'b1111) << off.
// - wdata = lsu_wdata_i << (8*off); unused lanes carry shifted data (don't care).
// Load data path:
// - sh = data_rdata_i >> (8*off).
// - Byte: bits[7:0], extend bit 7 if sign_ext, else zero.
// - Half: bits[15:0], extend bit 15 if sign_ext, else zero.
// - Word: unchanged.
// Timing and throughput:
// - Latency from accept to lsu_valid_o = 1 (REQ) + gnt wait + rvalid wait + 1.
// - Minimum is 3 cycles with gnt in the first REQ cycle and rvalid one cycle later.
// - lsu_ready_o returns high in the same cycle lsu_valid_o pulses, so back-to-back accepts are allowed.
// - Requests while not ready are ignored; the execute stage holds lsu_req_i until lsu_ready_o.
// TESTING
// 1. Load word:
//    - Stimulus: addr=0x1000, size=10; gnt first REQ cycle; rvalid next cycle with rdata=0xDEADBEEF.
//    - Required: data_addr_o=0x1000, be=1111; lsu_rdata_o=0xDEADBEEF with lsu_valid_o 3 cycles after accept.
// 2. Signed byte load:
//    - Stimulus: addr=0x1003, sign_ext=1, rdata=0x80112233.
//    - Required: be=1000, lsu_rdata_o=0xFFFFFF80.
//    - Repeat with sign_ext=0: lsu_rdata_o=0x00000080.
// 3. Store half:
//    - Stimulus: addr=0x2002, wdata=0x0000ABCD, gnt held low 4 cycles.
//    - Required: data_req_o high 5 cycles with addr=0x2000, be=1100, wdata=0xABCD0000 stable; lsu_rdata_o=0.
// 4. Misaligned accesses:
//    - Stimulus: word at 0x1001, half at 0x1003, size=11.
//    - Required: lsu_err_o pulses once each, data_req_o never asserts, lsu_ready_o stays 1.
// 5. Reset mid-access:
//    - Stimulus: assert rst_n=0 in RESP, release, then drive a stray rvalid.
//    - Required: all outputs at reset values, no lsu_valid_o; next load completes normally.
// 6. Back-to-back:
//    - Stimulus: second lsu_req_i held high through the first access.
//    - Required: second request accepted in the lsu_valid_o cycle; exactly two valid pulses, in order.

Source files
------------

// File: rtl/lsu_stage.sv
// ---------------------------------------------------------------------------
// lsu_stage
//
// Load/store unit that sits between the execute stage and a req/gnt/rvalid
// data-memory port. Only one access is in flight at a time.
//
// Ports
//   clk, rst_n        core clock (rising edge), asynchronous active-low reset
//   lsu_req_i         execute stage requests an access (fields valid while high)
//   lsu_we_i          1 = store, 0 = load
//   lsu_size_i        00 byte, 01 half, 10 word, 11 illegal
//   lsu_sign_ext_i    loads: 1 = sign-extend, 0 = zero-extend
//   lsu_addr_i        effective address
//   lsu_wdata_i       store data, LSB-justified
//   lsu_ready_o       unit is idle and accepts lsu_req_i this cycle
//   lsu_valid_o       one-cycle pulse: access completed
//   lsu_rdata_o       extended load data (0 for stores), valid with lsu_valid_o
//   lsu_err_o         one-cycle pulse: misaligned/illegal access, no bus traffic
//   data_req_o        bus request, held until data_gnt_i
//   data_gnt_i        bus grant
//   data_addr_o       word-aligned bus address
//   data_we_o         bus write enable
//   data_be_o         byte enables
//   data_wdata_o      lane-shifted store data
//   data_rvalid_i     bus response valid (loads and stores)
//   data_rdata_i      bus read data
// ---------------------------------------------------------------------------
module lsu_stage #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lsu_req_i,
    input  logic                  lsu_we_i,
    input  logic [1:0]            lsu_size_i,
    input  logic                  lsu_sign_ext_i,
    input  logic [WORD_WIDTH-1:0] lsu_addr_i,
    input  logic [WORD_WIDTH-1:0] lsu_wdata_i,
    output logic                  lsu_ready_o,
    output logic                  lsu_valid_o,
    output logic [WORD_WIDTH-1:0] lsu_rdata_o,
    output logic                  lsu_err_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    output logic [WORD_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [WORD_WIDTH-1:0] data_wdata_o,
    input  logic                  data_rvalid_i,
    input  logic [WORD_WIDTH-1:0] data_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                state_q;
    logic                  ready_q;
    logic                  req_q;
    logic                  valid_q;
    logic                  err_q;
    logic [WORD_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  sign_q;
    logic [3:0]            be_q;
    logic [WORD_WIDTH-1:0] wdata_q;
    logic [WORD_WIDTH-1:0] rdata_q;

    // Request-side decode, evaluated on the incoming request
    logic [1:0]            req_off;
    logic                  req_legal;
    logic [3:0]            be_d;
    logic [WORD_WIDTH-1:0] wdata_d;

    // Response-side data path, driven by the registered access fields
    logic [WORD_WIDTH-1:0] rdata_shifted;
    logic [WORD_WIDTH-1:0] rdata_d;

    assign req_off = lsu_addr_i[1:0];

    always_comb begin
        req_legal = 1'b0;
        be_d      = 4'b0000;
        case (lsu_size_i)
            2'b00: begin
                req_legal = 1'b1;
                be_d      = 4'b0001 << req_off;
            end
            2'b01: begin
                req_legal = ~req_off[0];
                be_d      = 4'b0011 << req_off;
            end
            2'b10: begin
                req_legal = (req_off == 2'b00);
                be_d      = 4'b1111 << req_off;
            end
            default: begin
                req_legal = 1'b0;
                be_d      = 4'b0000;
            end
        endcase
    end

    // Store data moves into the addressed lanes; lanes outside be are don't-care.
    assign wdata_d = lsu_wdata_i << {req_off, 3'b000};

    // Bring the addressed lanes down to bit 0, then extend to full width.
    assign rdata_shifted = data_rdata_i >> {addr_q[1:0], 3'b000};

    always_comb begin
        rdata_d = rdata_shifted;
        case (size_q)
            2'b00:   rdata_d = {{(WORD_WIDTH-8){sign_q & rdata_shifted[7]}},
                                rdata_shifted[7:0]};
            2'b01:   rdata_d = {{(WORD_WIDTH-16){sign_q & rdata_shifted[15]}},
                                rdata_shifted[15:0]};
            default: rdata_d = rdata_shifted;
        endcase
        // Stores still get a bus response, but report zero data.
        if (we_q) begin
            rdata_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (lsu_req_i) begin
                        if (req_legal) begin
                            addr_q  <= lsu_addr_i;
                            we_q    <= lsu_we_i;
                            size_q  <= lsu_size_i;
                            sign_q  <= lsu_sign_ext_i;
                            be_q    <= be_d;
                            wdata_q <= wdata_d;
                            ready_q <= 1'b0;
                            req_q   <= 1'b1;
                            state_q <= ST_REQ;
                        end else begin
                            // Rejected without touching the bus; unit stays ready.
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (data_gnt_i) begin
                        req_q   <= 1'b0;
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // A response arriving while IDLE (e.g. after a reset
                    // dropped an access) never reaches this branch.
                    if (data_rvalid_i) begin
                        rdata_q <= rdata_d;
                        valid_q <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    req_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign lsu_ready_o  = ready_q;
    assign lsu_valid_o  = valid_q;
    assign lsu_rdata_o  = rdata_q;
    assign lsu_err_o    = err_q;
    assign data_req_o   = req_q;
    assign data_addr_o  = {addr_q[WORD_WIDTH-1:2], 2'b00};
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu_stage.sv
// ---------------------------------------------------------------------------
// tb_lsu_stage
//
// Directed bench for lsu_stage. Expected load results are queued when a
// request is driven and popped whenever the unit pulses lsu_valid_o.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_lsu_stage;

    logic        clk;
    logic        rst_n;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [1:0]  lsu_size_i;
    logic        lsu_sign_ext_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_ready_o;
    logic        lsu_valid_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_err_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    int          checks;
    int          errors;
    int          valid_cnt;
    int          err_cnt;
    logic [31:0] exp_q[$];
    logic [31:0] exp_r;

    lsu_stage #(.WORD_WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .lsu_req_i      (lsu_req_i),
        .lsu_we_i       (lsu_we_i),
        .lsu_size_i     (lsu_size_i),
        .lsu_sign_ext_i (lsu_sign_ext_i),
        .lsu_addr_i     (lsu_addr_i),
        .lsu_wdata_i    (lsu_wdata_i),
        .lsu_ready_o    (lsu_ready_o),
        .lsu_valid_o    (lsu_valid_o),
        .lsu_rdata_o    (lsu_rdata_o),
        .lsu_err_o      (lsu_err_o),
        .data_req_o     (data_req_o),
        .data_gnt_i     (data_gnt_i),
        .data_addr_o    (data_addr_o),
        .data_we_o      (data_we_o),
        .data_be_o      (data_be_o),
        .data_wdata_o   (data_wdata_o),
        .data_rvalid_i  (data_rvalid_i),
        .data_rdata_i   (data_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs == expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Advance one clock; score any completion against the queue.
    task automatic step();
        @(posedge clk);
        #1;
        if (lsu_valid_o === 1'b1) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                chk1("valid_unexpected", lsu_valid_o, 1'b0);
            end else begin
                exp_r = exp_q.pop_front();
                chk32("rdata", lsu_rdata_o, exp_r);
            end
        end
        if (lsu_err_o === 1'b1) err_cnt++;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_ready"}, lsu_ready_o, 1'b1);
        chk1({tag, "_valid"}, lsu_valid_o, 1'b0);
        chk32({tag, "_rdata"}, lsu_rdata_o, 32'h0);
        chk1({tag, "_err"}, lsu_err_o, 1'b0);
        chk1({tag, "_req"}, data_req_o, 1'b0);
        chk32({tag, "_addr"}, data_addr_o, 32'h0);
        chk1({tag, "_we"}, data_we_o, 1'b0);
        chk32({tag, "_be"}, {28'h0, data_be_o}, 32'h0);
        chk32({tag, "_wdata"}, data_wdata_o, 32'h0);
    endtask

    task automatic drive_req(input logic we, input logic [1:0] size, input logic sext,
                             input logic [31:0] addr, input logic [31:0] wdata);
        lsu_req_i      = 1'b1;
        lsu_we_i       = we;
        lsu_size_i     = size;
        lsu_sign_ext_i = sext;
        lsu_addr_i     = addr;
        lsu_wdata_i    = wdata;
    endtask

    // One complete access with a given grant delay; rvalid follows one cycle after gnt.
    task automatic access(input string name, input logic we, input logic [1:0] size,
                          input logic sext, input logic [31:0] addr, input logic [31:0] wdata,
                          input int gnt_wait, input logic [31:0] bus_rdata,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
        int v0;
        v0 = valid_cnt;
        chk1({name, "_ready_idle"}, lsu_ready_o, 1'b1);
        drive_req(we, size, sext, addr, wdata);
        exp_q.push_back(exp_rdata);
        step();
        lsu_req_i = 1'b0;
        for (int c = 0; c <= gnt_wait; c++) begin
            chk1({name, "_req"}, data_req_o, 1'b1);
            chk1({name, "_ready_busy"}, lsu_ready_o, 1'b0);
            chk32({name, "_addr"}, data_addr_o, exp_addr);
            chk32({name, "_be"}, {28'h0, data_be_o}, {28'h0, exp_be});
            chk1({name, "_we"}, data_we_o, we);
            if (we) chk32({name, "_wdata"}, data_wdata_o, exp_wdata);
            data_gnt_i = (c == gnt_wait);
            step();
        end
        data_gnt_i = 1'b0;
        chk1({name, "_req_dropped"}, data_req_o, 1'b0);
        chk1({name, "_valid_early"}, lsu_valid_o, 1'b0);
        data_rvalid_i = 1'b1;
        data_rdata_i  = bus_rdata;
        step();
        data_rvalid_i = 1'b0;
        data_rdata_i  = 32'h0;
        chk1({name, "_valid"}, lsu_valid_o, 1'b1);
        chk1({name, "_ready_back"}, lsu_ready_o, 1'b1);
        $display("txn %s we=%0d size=%0d addr=%h rdata=%h", name, we, size, addr, lsu_rdata_o);
        step();
        chk1({name, "_valid_pulse"}, lsu_valid_o, 1'b0);
        chk_int({name, "_valid_count"}, valid_cnt - v0, 1);
    endtask

    initial begin
        int e0;
        int v0;
        checks = 0; errors = 0; valid_cnt = 0; err_cnt = 0;
        rst_n = 1'b0;
        lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 2'b00; lsu_sign_ext_i = 1'b0;
        lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // Load word, minimum latency
        access("ld_word", 1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 0, 32'hDEAD_BEEF,
               32'h0000_1000, 4'b1111, 32'h0, 32'hDEAD_BEEF);
        // Byte loads at offset 3, signed and unsigned
        access("ld_byte_s", 1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 0, 32'h8011_2233,
               32'h0000_1000, 4'b1000, 32'h0, 32'hFFFF_FF80);
        access("ld_byte_u", 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 0, 32'h8011_2233,
               32'h0000_1000, 4'b1000, 32'h0, 32'h0000_0080);
        // Half loads, upper and lower half
        access("ld_half_s", 1'b0, 2'b01, 1'b1, 32'h0000_1002, 32'h0, 1, 32'h8001_0000,
               32'h0000_1000, 4'b1100, 32'h0, 32'hFFFF_8001);
        access("ld_half_u", 1'b0, 2'b01, 1'b0, 32'h0000_1000, 32'h0, 0, 32'h1234_F00D,
               32'h0000_1000, 4'b0011, 32'h0, 32'h0000_F00D);
        // Store half with grant held off for 4 cycles
        access("st_half", 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 4, 32'h5555_5555,
               32'h0000_2000, 4'b1100, 32'hABCD_0000, 32'h0);
        // Store byte at offset 1
        access("st_byte", 1'b1, 2'b00, 1'b0, 32'h0000_2001, 32'h0000_00A5, 0, 32'h0,
               32'h0000_2000, 4'b0010, 32'h0000_A500, 32'h0);

        // Misaligned / illegal requests
        e0 = err_cnt;
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_1001, 32'h0);
        step();
        lsu_req_i = 1'b0;
        chk1("mis_word_err", lsu_err_o, 1'b1);
        chk1("mis_word_req", data_req_o, 1'b0);
        chk1("mis_word_ready", lsu_ready_o, 1'b1);
        $display("txn mis_word addr=00001001 err=%0d", lsu_err_o);
        step();
        chk1("mis_word_err_pulse", lsu_err_o, 1'b0);
        chk1("mis_word_req2", data_req_o, 1'b0);
        drive_req(1'b0, 2'b01, 1'b0, 32'h0000_1003, 32'h0);
        step();
        lsu_req_i = 1'b0;
        chk1("mis_half_err", lsu_err_o, 1'b1);
        chk1("mis_half_req", data_req_o, 1'b0);
        chk1("mis_half_ready", lsu_ready_o, 1'b1);
        $display("txn mis_half addr=00001003 err=%0d", lsu_err_o);
        step();
        chk1("mis_half_req2", data_req_o, 1'b0);
        drive_req(1'b1, 2'b11, 1'b0, 32'h0000_1000, 32'h1);
        step();
        lsu_req_i = 1'b0;
        chk1("size11_err", lsu_err_o, 1'b1);
        chk1("size11_req", data_req_o, 1'b0);
        chk1("size11_ready", lsu_ready_o, 1'b1);
        $display("txn size11 addr=00001000 err=%0d", lsu_err_o);
        step();
        chk1("size11_req2", data_req_o, 1'b0);
        chk1("size11_err_pulse", lsu_err_o, 1'b0);
        chk_int("mis_err_count", err_cnt - e0, 3);

        // Reset while waiting for the response
        v0 = valid_cnt;
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0);
        step();
        lsu_req_i = 1'b0;
        data_gnt_i = 1'b1;
        step();
        data_gnt_i = 1'b0;
        chk1("rst_in_resp_ready", lsu_ready_o, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hCAFE_F00D;
        step();
        data_rvalid_i = 1'b0;
        data_rdata_i  = 32'h0;
        chk1("stray_valid", lsu_valid_o, 1'b0);
        chk1("stray_ready", lsu_ready_o, 1'b1);
        chk1("stray_req", data_req_o, 1'b0);
        step();
        chk1("stray_valid2", lsu_valid_o, 1'b0);
        chk_int("rst_no_valid", valid_cnt - v0, 0);
        $display("txn reset_mid_access dropped");
        access("ld_after_rst", 1'b0, 2'b10, 1'b0, 32'h0000_4004, 32'h0, 0, 32'h0BAD_F00D,
               32'h0000_4004, 4'b1111, 32'h0, 32'h0BAD_F00D);

        // Back-to-back: second request held through the first access
        v0 = valid_cnt;
        chk1("b2b_ready", lsu_ready_o, 1'b1);
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0);
        exp_q.push_back(32'h0102_0304);
        step();
        drive_req(1'b0, 2'b00, 1'b1, 32'h0000_3001, 32'h0);
        exp_q.push_back(32'hFFFF_FFFF);
        chk1("b2b_a_req", data_req_o, 1'b1);
        chk32("b2b_a_be", {28'h0, data_be_o}, 32'h0000_000F);
        data_gnt_i = 1'b1;
        step();
        data_gnt_i = 1'b0;
        chk1("b2b_held_ready", lsu_ready_o, 1'b0);
        chk1("b2b_held_req", data_req_o, 1'b0);
        chk32("b2b_held_be", {28'h0, data_be_o}, 32'h0000_000F);
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h0102_0304;
        step();
        data_rvalid_i = 1'b0;
        data_rdata_i  = 32'h0;
        chk1("b2b_a_valid", lsu_valid_o, 1'b1);
        chk1("b2b_a_ready", lsu_ready_o, 1'b1);
        $display("txn b2b_a addr=00003000 rdata=%h", lsu_rdata_o);
        step();
        lsu_req_i = 1'b0;
        chk1("b2b_b_accept", data_req_o, 1'b1);
        chk1("b2b_b_valid_low", lsu_valid_o, 1'b0);
        chk32("b2b_b_be", {28'h0, data_be_o}, 32'h0000_0002);
        data_gnt_i = 1'b1;
        step();
        data_gnt_i = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h0000_FF00;
        step();
        data_rvalid_i = 1'b0;
        data_rdata_i  = 32'h0;
        chk1("b2b_b_valid", lsu_valid_o, 1'b1);
        $display("txn b2b_b addr=00003001 rdata=%h", lsu_rdata_o);
        step();
        step();
        chk_int("b2b_valid_count", valid_cnt - v0, 2);
        chk_int("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
